data_stream_axil_writer: RTL

DATA_STREAM_AXIL_WRITER -- requirements
Module: data_stream_axil_writer

---
 rtl/data_stream_axil_writer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/data_stream_axil_writer.sv
// data_stream_axil_writer
//   Takes beats from a valid/ready stream and writes each one to consecutive
//   word slots through an AXI-Lite master port. Only one write is in flight
//   at a time. The address wraps after NUM_WORDS slots.
//
// Parameters
//   DATA_WIDTH  stream / AXI-Lite data width (32 or 64)
//   ADDR_WIDTH  AXI-Lite address width
//   BASE_ADDR   address of slot 0 (aligned to DATA_WIDTH/8)
//   NUM_WORDS   number of slots before the address wraps (>= 2)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_data/s_strb/s_valid/s_ready   stream slave
//   m_axi_aw*                  AXI-Lite write address channel (awprot = 0)
//   m_axi_w*                   AXI-Lite write data channel
//   m_axi_b*                   AXI-Lite write response channel
//   clr                        clears slot index and err (honoured in IDLE only)
//   err                        sticky: some write response was not OKAY
//   busy                       FSM is not in IDLE
//
// Build option
//   DATA_STREAM_AXIL_WRITER_ZERO_STRB_SKIP_EN: beats with s_strb == 0 are
//   consumed without an AXI write but still advance the slot index.
module data_stream_axil_writer #(
  parameter int unsigned                 DATA_WIDTH = 32,
  parameter int unsigned                 ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]       BASE_ADDR  = '0,
  parameter int unsigned                 NUM_WORDS  = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_strb,
  input  logic                    s_valid,
  output logic                    s_ready,

  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,

  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,

  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,

  input  logic                    clr,
  output logic                    err,
  output logic                    busy
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic                    rdy_en;   // holds s_ready low until the first edge after reset
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_inc;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic                    aw_done;
  logic                    w_done;

  logic                    s_hs;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    b_hs;
  logic                    skip;

  assign s_hs  = s_ready & s_valid;
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;
  assign b_hs  = m_axi_bready & m_axi_bvalid;

`ifdef DATA_STREAM_AXIL_WRITER_ZERO_STRB_SKIP_EN
  assign skip = (s_strb == '0);
`else
  assign skip = 1'b0;
`endif

  assign idx_inc = (idx == IDX_W'(NUM_WORDS - 1)) ? '0 : idx + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (s_hs && !skip) state_nxt = WRITE;
      // AW and W may complete in either order; a handshake this cycle counts
      WRITE: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = RESP;
      RESP:  if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    s_ready       = rdy_en && (state == IDLE);
    m_axi_awvalid = (state == WRITE) && !aw_done;
    m_axi_wvalid  = (state == WRITE) && !w_done;
    m_axi_bready  = (state == RESP);
    busy          = (state != IDLE);
  end

  // Datapath: capture, channel-done flags, slot index, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en  <= 1'b0;
      idx     <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      unique case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (s_hs && !skip) begin
            data_q <= s_data;
            strb_q <= s_strb;
          end
          // clr wins over a skipped beat's index advance
          if (clr) begin
            idx   <= '0;
            err_q <= 1'b0;
          end else if (s_hs && skip) begin
            idx <= idx_inc;
          end
        end
        WRITE: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        RESP: begin
          if (b_hs) begin
            idx <= idx_inc;
            if (m_axi_bresp != 2'b00) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi_awaddr = BASE_ADDR + (ADDR_WIDTH'(idx) * ADDR_WIDTH'(STRB_WIDTH));
  assign m_axi_awprot = 3'b000;
  assign m_axi_wdata  = data_q;
  assign m_axi_wstrb  = strb_q;
  assign err          = err_q;

endmodule
